// File: rtl/fetch_unit.sv
// F-stage PC owner: issues synchronous IM reads and presents F_PC/F_Instr to the F/D register.
// Handles F/D stalls, taken branches (delay slot kept), exception/eret restarts and AdEL fetch faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WrEn,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        restart,
  input  logic [31:0] restart_pc,
  output logic        im_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic        F_Valid,
  output logic        F_ExcAdEL
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, FAULT} state_t;

  // One bit wider than an address so a window reaching 2^32 does not wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [31:0] next_addr;
  logic        next_legal;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IM_BASE) && ({1'b0, a} < IM_LIMIT);
  endfunction

  assign next_addr  = restart             ? restart_pc      :
                      (redirect && WrEn)  ? redirect_target :
                                            pc_q + 32'd4;
  assign next_legal = legal(next_addr);
  assign F_PC       = pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= BOOT;
      pc_q   <= '0;
      hold_q <= '0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      hold_q <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    hold_nxt  = hold_q;
    im_en     = 1'b0;
    im_addr   = pc_q;
    F_Instr   = '0;
    F_Valid   = 1'b0;
    F_ExcAdEL = 1'b0;

    case (state)
      BOOT: begin
        im_addr   = RESET_PC;
        im_en     = legal(RESET_PC);
        pc_nxt    = RESET_PC;
        state_nxt = legal(RESET_PC) ? RUN : FAULT;
      end
      RUN, HOLD: begin
        F_Instr = (state == RUN) ? im_rdata : hold_q;
        F_Valid = 1'b1;
        if (WrEn) begin
          im_addr   = next_addr;
          im_en     = next_legal;
          pc_nxt    = next_addr;
          state_nxt = next_legal ? RUN : FAULT;
        end else if (state == RUN) begin
          // Capture the returned word so the IM can sit idle for the whole stall.
          hold_nxt  = im_rdata;
          state_nxt = HOLD;
        end
      end
      FAULT: begin
        F_ExcAdEL = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase

    // Restart overrides everything, including a pending stall; held data is dropped.
    if (restart) begin
      im_addr   = restart_pc;
      im_en     = next_legal;
      pc_nxt    = restart_pc;
      hold_nxt  = '0;
      state_nxt = next_legal ? RUN : FAULT;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus a reset-during-stall sequence.
// The IM model returns an address-derived word one cycle after a request, garbage otherwise.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        WrEn;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        restart;
  logic [31:0] restart_pc;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_Valid;
  logic        F_ExcAdEL;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic        redir;
    logic [31:0] tgt;
    logic        rs;
    logic [31:0] rpc;
    logic        e_en;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_v;
    logic        e_exc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .WrEn            (WrEn),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .restart         (restart),
    .restart_pc      (restart_pc),
    .im_en           (im_en),
    .im_addr         (im_addr),
    .im_rdata        (im_rdata),
    .F_PC            (F_PC),
    .F_Instr         (F_Instr),
    .F_Valid         (F_Valid),
    .F_ExcAdEL       (F_ExcAdEL)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Synchronous IM: valid data only for a request made in the previous cycle.
  always @(posedge clk) begin
    if (im_en) im_rdata <= memword(im_addr);
    else       im_rdata <= $urandom();
  end

  function automatic vec_t mk(input logic rst, we, redir, input logic [31:0] tgt,
                              input logic rs, input logic [31:0] rpc,
                              input logic e_en, input logic [31:0] e_addr, e_pc,
                              input logic e_v, e_exc);
    vec_t v;
    v.rst = rst; v.we = we; v.redir = redir; v.tgt = tgt; v.rs = rs; v.rpc = rpc;
    v.e_en = e_en; v.e_addr = e_addr; v.e_pc = e_pc; v.e_v = e_v; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic compare(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset           = v.rst;
    WrEn            = v.we;
    redirect        = v.redir;
    redirect_target = v.tgt;
    restart         = v.rs;
    restart_pc      = v.rpc;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    compare("im_en",     row, {31'b0, im_en},     {31'b0, v.e_en});
    if (v.e_en) compare("im_addr", row, im_addr, v.e_addr);
    compare("F_PC",      row, F_PC,               v.e_pc);
    compare("F_Valid",   row, {31'b0, F_Valid},   {31'b0, v.e_v});
    compare("F_ExcAdEL", row, {31'b0, F_ExcAdEL}, {31'b0, v.e_exc});
    compare("F_Instr",   row, F_Instr,            v.e_v ? memword(v.e_pc) : 32'h0);
  endtask

  initial begin
    //              rst we rd tgt           rs rpc           en addr          pc            v  exc
    vecs.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3000, 32'h0,    0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3000, 32'h0,    0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3004, 32'h3000, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3008, 32'h3004, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h3008, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'h3100,   0, 32'h0,      0, 32'h0,    32'h3008, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h3008, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h300C, 32'h3008, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3010, 32'h300C, 1, 0));
    vecs.push_back(mk(1, 1, 1, 32'h3100,   0, 32'h0,      1, 32'h3100, 32'h3010, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3104, 32'h3100, 1, 0));
    vecs.push_back(mk(1, 1, 1, 32'h3102,   0, 32'h0,      0, 32'h0,    32'h3104, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h3102, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,      1, 32'h4180,   1, 32'h4180, 32'h3102, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h4184, 32'h4180, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h4184, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,      1, 32'h4180,   1, 32'h4180, 32'h4184, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h4184, 32'h4180, 1, 0));
    vecs.push_back(mk(1, 1, 1, 32'h6FF8,   0, 32'h0,      1, 32'h6FF8, 32'h4184, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h6FFC, 32'h6FF8, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h6FFC, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h7000, 0, 1));
    vecs.push_back(mk(1, 0, 1, 32'h3000,   0, 32'h0,      0, 32'h0,    32'h7000, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h7000, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3000, 32'h0,    0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3004, 32'h3000, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      1, 32'h2FFC,   0, 32'h0,    32'h3004, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h2FFC, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,      1, 32'h3000,   1, 32'h3000, 32'h2FFC, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,    32'h3000, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      1, 32'h3004, 32'h3000, 1, 0));

    reset = 1'b0; WrEn = 1'b1; redirect = 1'b0; redirect_target = '0;
    restart = 1'b0; restart_pc = '0;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // Reset asserted in the middle of a stall: held word must not survive.
    @(negedge clk);
    reset = 1'b1; WrEn = 1'b0; redirect = 1'b0; restart = 1'b0;
    @(negedge clk);
    #1;
    compare("stall_instr", 100, F_Instr, memword(32'h3004));
    compare("stall_im_en", 100, {31'b0, im_en}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; WrEn = 1'b1;
    #1;
    compare("boot_pc",     101, F_PC, 32'h0);
    compare("boot_valid",  101, {31'b0, F_Valid}, 32'h0);
    compare("boot_instr",  101, F_Instr, 32'h0);
    compare("boot_addr",   101, im_addr, 32'h3000);
    @(negedge clk);
    #1;
    compare("rerun_pc",    102, F_PC, 32'h3000);
    compare("rerun_instr", 102, F_Instr, memword(32'h3000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
